xpb_lut_ram: RTL

Runtime-loadable, multi-channel replacement for the fixed-constant XPB lookup tables in the modular-squaring datapath. Holds the 2^SEL_BITS − 1 nonzero precomputed reduction multiples for one segment, loaded word-by-word from a narrow stream, and serves NUM_CH independent registered lookups per cycle. Entry 0 is hard-wired to zero. A new modulus therefore needs only a table reload, not a re-synthesis.

---
 rtl/xpb_lut_ram.sv | 127 ++++++++++++
 1 files changed

// File: rtl/xpb_lut_ram.sv
// Runtime-loadable XPB reduction-multiple table: entries 1..2^SEL_BITS-1 are streamed in
// LOAD_WIDTH words, entry 0 reads as zero, NUM_CH registered lookups served per cycle.
module xpb_lut_ram #(
  parameter int unsigned SEL_BITS   = 5,
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned LOAD_WIDTH = 64,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [LOAD_WIDTH-1:0]        load_data,
  output logic                         load_ready,
  output logic                         table_ready,
  input  logic                         lookup_valid,
  input  logic [NUM_CH*SEL_BITS-1:0]   lookup_sel,
  output logic                         out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data
);

  localparam int unsigned WPE   = DATA_WIDTH / LOAD_WIDTH;
  localparam int unsigned WW    = (WPE > 1) ? $clog2(WPE) : 1;
  localparam int unsigned DEPTH = 2 ** SEL_BITS;
  localparam logic [WW-1:0]       WORD_LAST  = WW'(WPE - 1);
  localparam logic [SEL_BITS-1:0] ENTRY_LAST = '1;
  localparam logic [SEL_BITS-1:0] ENTRY_FIRST = SEL_BITS'(1);

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_t;

  state_t                       state_q, state_d;
  logic [WW-1:0]                word_q, word_d;
  logic [SEL_BITS-1:0]          entry_q, entry_d;
  logic [DATA_WIDTH-1:0]        asm_q, asm_d;
  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic                         accept;
  logic                         entry_done;
  logic                         lookup_acc;
  logic [SEL_BITS-1:0]          sel;
  logic                         out_valid_q;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data_q, out_data_d;

  // load_start has priority: a word presented alongside it is dropped.
  always_comb begin
    accept     = (state_q == LOAD) && load_valid && !load_start;
    entry_done = accept && (word_q == WORD_LAST);
    lookup_acc = lookup_valid && (state_q == READY);
  end

  // The assembled entry includes the word accepted this cycle, so the
  // final word writes the array directly from asm_d.
  always_comb begin
    asm_d = asm_q;
    for (int unsigned w = 0; w < WPE; w++) begin
      if (accept && (word_q == WW'(w))) begin
        asm_d[w*LOAD_WIDTH +: LOAD_WIDTH] = load_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    entry_d = entry_q;
    if (load_start) begin
      state_d = LOAD;
      word_d  = '0;
      entry_d = ENTRY_FIRST;
    end else if (accept) begin
      if (word_q == WORD_LAST) begin
        word_d  = '0;
        entry_d = entry_q + 1'b1;
        if (entry_q == ENTRY_LAST) begin
          state_d = READY;
        end
      end else begin
        word_d = word_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    sel        = '0;
    if (lookup_acc) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sel = lookup_sel[c*SEL_BITS +: SEL_BITS];
        out_data_d[c*DATA_WIDTH +: DATA_WIDTH] = (sel == '0) ? '0 : mem[sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      word_q      <= '0;
      entry_q     <= ENTRY_FIRST;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      entry_q     <= entry_d;
      asm_q       <= asm_d;
      out_valid_q <= lookup_acc;
      out_data_q  <= out_data_d;
    end
  end

  // Storage is deliberately not reset; only a complete load makes it valid.
  always_ff @(posedge clk) begin
    if (entry_done && !reset) begin
      mem[entry_q] <= asm_d;
    end
  end

  assign load_ready  = (state_q == LOAD);
  assign table_ready = (state_q == READY);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

endmodule
